h264_bytereader: RTL

//  Decoder-side counterpart of the encoder's byte packer.
//  - Accepts an Annex-B byte stream and detects 00 00 01 start codes.
//  - Strips emulation-prevention bytes (00 00 03 -> 00 00).
//  - Presents the following RBSP bits MSB-first in a left-aligned window, for header/CAVLC parsers.
//  - The consumer removes 0..MAXCONSUME bits per cycle; a leading-zero count is supplied for exp-Golomb.

---
 rtl/h264_pkg.sv | 14 +
 rtl/h264_lzc32.sv | 15 +
 rtl/h264_bytereader.sv | 95 +++++++++
 3 files changed

// File: rtl/h264_pkg.sv
// Shared H.264 Annex-B constants and types used by the bitstream front-end blocks.
package h264_pkg;

  localparam logic [7:0] H264_EPB_BYTE = 8'h03;
  localparam logic [7:0] H264_SC_BYTE  = 8'h01;

  typedef logic [1:0] zrun_t;

  // Saturating zero-byte run counter step.
  function automatic zrun_t zrun_inc(input zrun_t z);
    return (z == 2'd3) ? 2'd3 : zrun_t'(z + 2'd1);
  endfunction

endpackage

// File: rtl/h264_lzc32.sv
// 32-bit leading-zero counter; all-zero input yields 32.
module h264_lzc32 (
  input  logic [31:0] din,
  output logic [5:0]  lz
);

  always_comb begin
    lz = 6'd32;
    // Ascending scan: the last hit is the most significant set bit.
    for (int unsigned i = 0; i < 32; i++) begin
      if (din[i]) lz = 6'(31 - i);
    end
  end

endmodule

// File: rtl/h264_bytereader.sv
// Annex-B byte reader: start-code detection, emulation-prevention removal and a
// left-aligned RBSP bit window with consume/align and leading-zero count.
module h264_bytereader
  import h264_pkg::*;
#(
  parameter int unsigned BUFBITS    = 64,
  parameter int unsigned MAXCONSUME = 32,
  localparam int unsigned CW        = $clog2(BUFBITS) + 1,
  localparam int unsigned NW        = $clog2(MAXCONSUME) + 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [7:0]            BYTE,
  input  logic                  STROBE,
  output logic                  READY,
  output logic [MAXCONSUME-1:0] BITS,
  output logic [CW-1:0]         AVAIL,
  output logic [NW-1:0]         LZ,
  input  logic [NW-1:0]         CONSUME,
  input  logic                  CSTROBE,
  input  logic                  ALIGN,
  output logic                  NALSTART,
  output logic                  ERR
);

  logic [BUFBITS-1:0] buf_q;
  logic [CW-1:0]      count_q;
  zrun_t              zrun_q;
  logic               nal_q;
  logic               err_q;

  logic               accept, epb, sc, append;
  logic               consume_ok, over;
  logic [CW-1:0]      n, cnt_after, r, cnt_shift, shift_amt, ins_pos;
  logic [BUFBITS-1:0] shifted, byte_word;
  logic [NW-1:0]      lz_raw;

  assign READY    = (count_q <= CW'(BUFBITS - 8));
  assign BITS     = buf_q[BUFBITS-1 -: MAXCONSUME];
  assign AVAIL    = count_q;
  assign NALSTART = nal_q;
  assign ERR      = err_q;

  assign accept = STROBE && READY;
  assign epb    = accept && (zrun_q >= 2'd2) && (BYTE == H264_EPB_BYTE);
  assign sc     = accept && (zrun_q >= 2'd2) && (BYTE == H264_SC_BYTE);
  assign append = accept && !epb && !sc;

  assign consume_ok = CSTROBE && (CW'(CONSUME) <= count_q);
  assign over       = CSTROBE && (CW'(CONSUME) > count_q);

  // Align is evaluated on the post-consume count; the byte lands behind both shifts.
  always_comb begin
    n         = consume_ok ? CW'(CONSUME) : '0;
    cnt_after = count_q - n;
    r         = ALIGN ? CW'(cnt_after[2:0]) : '0;
    cnt_shift = cnt_after - r;
    shift_amt = n + r;
    ins_pos   = CW'(BUFBITS - 8) - cnt_shift;
    shifted   = buf_q << shift_amt;
    byte_word = BUFBITS'(BYTE) << ins_pos;
  end

  h264_lzc32 u_lzc (
    .din (buf_q[BUFBITS-1 -: 32]),
    .lz  (lz_raw)
  );

  // Bits beyond AVAIL are kept zero, so the raw count only needs clamping to AVAIL.
  assign LZ = (CW'(lz_raw) > count_q) ? NW'(count_q) : lz_raw;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      buf_q   <= '0;
      count_q <= '0;
      zrun_q  <= '0;
      nal_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      nal_q <= sc;
      if (sc) begin
        buf_q   <= '0;
        count_q <= '0;
        zrun_q  <= '0;
      end else begin
        buf_q   <= append ? (shifted | byte_word) : shifted;
        count_q <= append ? (cnt_shift + CW'(8)) : cnt_shift;
        if (over) err_q <= 1'b1;
        if (epb) zrun_q <= '0;
        else if (append) zrun_q <= (BYTE == 8'h00) ? zrun_inc(zrun_q) : '0;
      end
    end
  end

endmodule
